day5_match_writer: RTL and testbench
====================================

Name: day5_match_writer

Overview:
- Producer side of the Day 5 per-ID match-result memory. That memory is later summed to get the count of IDs that fall within any range.
- Accepts a stream of inclusive ranges, then a stream of IDs. For each ID it scans the stored ranges, one range per cycle.
- Writes one 32-bit word per ID (0 or 1) to the result memory write port at sequential addresses, and keeps a running match count.

Parameters:
- ID_W, 64, width of IDs and range bounds (unsigned).
- MAX_RANGES, 256, capacity of the internal range table.
- DEPTH, 1000, number of result-memory words.
- ADDR_W, 10, result-memory address width; must satisfy 2^ADDR_W >= DEPTH.
- RIDX_W, 8, range index width; must satisfy 2^RIDX_W >= MAX_RANGES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_kind  in  1  0 = range beat, 1 = ID beat
- in_lo  in  ID_W  range low bound, or the ID on ID beats
- in_hi  in  ID_W  range high bound; ignored on ID beats
- in_last  in  1  marks the final ID beat
- wr_en  out  1  result memory write strobe
- wr_addr  out  ADDR_W  result memory address
- wr_data  out  32  {31'b0, match_flag}
- match_count  out  32  running count of matching IDs
- id_count  out  ADDR_W+1  number of IDs written
- err  out  1  sticky protocol/overflow error
- done  out  1  sticky completion flag

Behaviour:
- Reset (clk edge with rst=1): all of the following clear.
  - Outputs: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, match_count=0, id_count=0, err=0, done=0.
  - Internal: range count nr=0, state=IDLE.
  - rst wins over every other event, including mid-scan or in the WRITE cycle; no write is issued in the reset cycle.
- Handshake: a beat transfers on a clk edge where in_valid & in_ready.
  - in_ready is registered and high only in LOAD.
  - No beat is accepted in IDLE, SCAN, WRITE or DONE; held in_valid must not be double-counted.
- States:
  - IDLE: one cycle after reset, then go to LOAD.
  - LOAD: in_ready=1.
    - Range beat: if no ID has been accepted yet and nr<MAX_RANGES, store {lo,hi} at index nr and increment nr. Otherwise drop the beat and set err.
    - ID beat: latch the ID and in_last, and set idx=0. If nr==0, go to WRITE with flag=0; else go to SCAN.
  - SCAN: one range compared per cycle; hit = (lo<=id) && (id<=hi), unsigned and inclusive.
    - lo>hi never matches.
    - On hit, go to WRITE with flag=1 (early exit).
    - On miss with idx==nr-1, go to WRITE with flag=0.
    - Otherwise idx++.
  - WRITE: lasts exactly one cycle.
    - If id_count<DEPTH: wr_en=1, wr_addr=id_count, wr_data={31'b0,flag}, match_count+=flag, id_count++.
    - Else: no write, no count, set err.
    - Next state is DONE if the latched last flag is set, else LOAD.
  - DONE: done=1 and in_ready=0 until reset.
- Latency: with the ID accepted at edge E, wr_en is high during cycle E+k+1.
  - k = index of the first matching range + 1.
  - k = nr if no range matches.
  - k = 0 if nr==0.
- Back-to-back IDs: in_ready returns in the cycle after WRITE, so the minimum ID period is k+2 cycles.
- Arithmetic: match_count and id_count saturate and never wrap. wr_en, wr_addr and wr_data are meaningful only while wr_en=1; wr_en is low in every other state.

Test Plan:
- Example dataset: ranges [3,5],[10,14],[16,20],[12,18]; IDs 1,5,8,11,17,32 (last on 32).
  - Writes: addr0..5 = 0,1,0,1,1,0.
  - Final: match_count=3, id_count=6, done=1, err=0.
- Latency: same ranges.
  - ID 5 (hits range 0) -> wr_en exactly 2 cycles after acceptance.
  - ID 1 (no hit) -> 5 cycles.
  - in_valid held high throughout yields exactly one write per ID.
- Boundaries: ranges [7,7] and [9,2]; IDs 7, 2, 9, 2^64-1 -> flags 1,0,0,0.
  - Then range [0,2^64-1] sent after the IDs -> dropped, err=1.
- Empty table: no ranges; IDs 4,4 (last) -> both flags 0, each written 1 cycle after acceptance, match_count=0.
- Overflow:
  - MAX_RANGES+1 range beats -> last one dropped, err=1, and matching uses only the first MAX_RANGES.
  - DEPTH+1 IDs -> final ID not written, id_count=DEPTH, err=1.
- Reset mid-SCAN (ranges loaded, ID 17 scanning): no wr_en is issued.
  - All outputs return to reset values and nr=0.
  - Reloading the example dataset reproduces match_count=3.

Source files
------------

// File: rtl/day5_match_writer.sv
// day5_match_writer: loads inclusive ID ranges, then scans one range per cycle for each ID
// and writes a 0/1 match word per ID to sequential result-memory addresses.
module day5_match_writer #(
   parameter int ID_W       = 64,
   parameter int MAX_RANGES = 256,
   parameter int DEPTH      = 1000,
   parameter int ADDR_W     = 10,
   parameter int RIDX_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_kind,
   input  logic [ID_W-1:0]   in_lo,
   input  logic [ID_W-1:0]   in_hi,
   input  logic              in_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [31:0]       match_count,
   output logic [ADDR_W:0]   id_count,
   output logic              err,
   output logic              done
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_WRITE, S_DONE} state_t;
   localparam logic [RIDX_W:0] NR_MAX  = (RIDX_W+1)'(MAX_RANGES);
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
   state_t              state_q, state_d;
   logic [RIDX_W:0]     nr_q, nr_d;
   logic [RIDX_W-1:0]   idx_q, idx_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                last_q, last_d, flag_q, flag_d, seen_q, seen_d, err_q, err_d;
   logic                in_ready_q, wr_en_q, wr_en_d, wr_flag_q, wr_flag_d, done_q;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]         match_q, match_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [ID_W-1:0]     lo_mem [MAX_RANGES];
   logic [ID_W-1:0]     hi_mem [MAX_RANGES];
   logic                accept, store, hit, scan_end;
   assign accept   = in_valid & in_ready_q;
   assign store    = accept & ~in_kind & ~seen_q & (nr_q < NR_MAX);
   assign hit      = (lo_mem[idx_q] <= id_q) && (id_q <= hi_mem[idx_q]);
   assign scan_end = {1'b0, idx_q} == nr_q - 1'b1;
   assign in_ready    = in_ready_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = {31'b0, wr_flag_q};
   assign match_count = match_q;
   assign id_count    = cnt_q;
   assign err         = err_q;
   assign done        = done_q;
   // Range table is plain storage; validity is tracked by nr_q alone.
   always_ff @(posedge clk) begin
      if (store) begin
         lo_mem[nr_q[RIDX_W-1:0]] <= in_lo;
         hi_mem[nr_q[RIDX_W-1:0]] <= in_hi;
      end
   end
   always_comb begin
      state_d   = state_q;
      nr_d      = nr_q;
      idx_d     = idx_q;
      id_d      = id_q;
      last_d    = last_q;
      flag_d    = flag_q;
      seen_d    = seen_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_flag_d = wr_flag_q;
      match_d   = match_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: state_d = S_LOAD;
         S_LOAD: begin
            if (accept && !in_kind) begin
               if (store) nr_d = nr_q + 1'b1;
               else err_d = 1'b1;
            end else if (accept) begin
               seen_d  = 1'b1;
               id_d    = in_lo;
               last_d  = in_last;
               idx_d   = '0;
               flag_d  = 1'b0;
               state_d = (nr_q == '0) ? S_WRITE : S_SCAN;
            end
         end
         S_SCAN: begin
            if (hit || scan_end) state_d = S_WRITE;
            else idx_d = idx_q + 1'b1;
            flag_d = hit;
         end
         S_WRITE: begin
            if (cnt_q < CNT_MAX) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q[ADDR_W-1:0];
               wr_flag_d = flag_q;
               match_d   = (flag_q && match_q != '1) ? match_q + 32'd1 : match_q;
               cnt_d     = cnt_q + 1'b1;
            end else begin
               err_d = 1'b1;
            end
            state_d = last_q ? S_DONE : S_LOAD;
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         nr_q       <= '0;
         idx_q      <= '0;
         id_q       <= '0;
         last_q     <= 1'b0;
         flag_q     <= 1'b0;
         seen_q     <= 1'b0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_flag_q  <= 1'b0;
         match_q    <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         nr_q       <= nr_d;
         idx_q      <= idx_d;
         id_q       <= id_d;
         last_q     <= last_d;
         flag_q     <= flag_d;
         seen_q     <= seen_d;
         err_q      <= err_d;
         in_ready_q <= state_d == S_LOAD;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_flag_q  <= wr_flag_d;
         match_q    <= match_d;
         cnt_q      <= cnt_d;
         done_q     <= state_d == S_DONE;
      end
   end
endmodule

// File: tb/tb_day5_match_writer.sv
// tb_day5_match_writer: randomized and directed stimulus, queue-based reference model,
// scoreboard monitor checking address, data and write cycle of every result word.
module tb_day5_match_writer;
   localparam int MAXR = 256, DEPTH = 1000, LIM = 2000;
   logic clk = 0, rst = 1, in_valid = 0, in_kind = 0, in_last = 0;
   logic [63:0] in_lo = '0, in_hi = '0;
   logic in_ready, wr_en, err, done;
   logic [9:0] wr_addr;
   logic [31:0] wr_data, match_count;
   logic [10:0] id_count;
   day5_match_writer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_lo(in_lo), .in_hi(in_hi), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .match_count(match_count), .id_count(id_count), .err(err), .done(done)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0, errors = 0;
   typedef struct {int addr; int flag; int due;} exp_t;
   exp_t sb[$];
   exp_t e;
   logic [63:0] m_lo[$], m_hi[$];
   bit m_seen, m_err;
   int m_ids, m_match;
   logic [63:0] all1 = '1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (wr_en) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d", wr_addr, wr_data, cyc);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e.addr));
            chk("wr_data", 64'(wr_data), 64'(e.flag));
            chk("wr_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end
   task automatic do_reset();
      in_valid = 0;
      rst = 1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_wr_en", 64'(wr_en), 0);
      chk("rst_wr_addr", 64'(wr_addr), 0);
      chk("rst_wr_data", 64'(wr_data), 0);
      chk("rst_match_count", 64'(match_count), 0);
      chk("rst_id_count", 64'(id_count), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_done", 64'(done), 0);
      rst = 0;
      m_lo.delete();
      m_hi.delete();
      m_seen = 0;
      m_err = 0;
      m_ids = 0;
      m_match = 0;
   endtask
   task automatic beat(input bit kind, input logic [63:0] lo, input logic [63:0] hi,
                       input bit last, output int acc);
      int n = 0;
      in_valid = 1;
      in_kind = kind;
      in_lo = lo;
      in_hi = hi;
      in_last = last;
      while (!in_ready && n < LIM) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: in_ready 0 after %0d cycles, required 1", n);
         acc = -1;
         return;
      end
      acc = cyc + 1;
      @(negedge clk);
   endtask
   task automatic gap(input int n);
      in_valid = 0;
      repeat (n) @(negedge clk);
   endtask
   task automatic send_range(input logic [63:0] lo, input logic [63:0] hi);
      int acc;
      beat(0, lo, hi, 0, acc);
      if (acc < 0) return;
      if (!m_seen && m_lo.size() < MAXR) begin
         m_lo.push_back(lo);
         m_hi.push_back(hi);
      end else m_err = 1;
   endtask
   task automatic send_id(input logic [63:0] id, input bit last, input bit push);
      int acc, h, k;
      beat(1, id, {$urandom, $urandom}, last, acc);
      if (acc < 0) return;
      m_seen = 1;
      h = -1;
      foreach (m_lo[i]) if (h < 0 && m_lo[i] <= id && id <= m_hi[i]) h = i;
      k = (h >= 0) ? h + 1 : m_lo.size();
      if (!push) return;
      if (m_ids < DEPTH) begin
         sb.push_back('{m_ids, (h >= 0) ? 1 : 0, acc + k + 1});
         m_ids++;
         m_match += (h >= 0) ? 1 : 0;
      end else m_err = 1;
   endtask
   task automatic finish_run(input string tag);
      int n = 0;
      in_valid = 0;
      while (!done && n < LIM) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk({tag, "_done"}, 64'(done), 1);
      chk({tag, "_in_ready"}, 64'(in_ready), 0);
      chk({tag, "_match_count"}, 64'(match_count), 64'(m_match));
      chk({tag, "_id_count"}, 64'(id_count), 64'(m_ids));
      chk({tag, "_err"}, 64'(err), 64'(m_err));
      chk({tag, "_sb_drained"}, 64'(sb.size()), 0);
   endtask
   task automatic load_example();
      send_range(3, 5);
      send_range(10, 14);
      send_range(16, 20);
      send_range(12, 18);
   endtask
   task automatic example_ids();
      send_id(1, 0, 1);
      send_id(5, 0, 1);
      send_id(8, 0, 1);
      send_id(11, 0, 1);
      send_id(17, 0, 1);
      send_id(32, 1, 1);
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [63:0] lo, hi;
      do_reset();
      load_example();
      example_ids();
      finish_run("example");
      chk("example_match3", 64'(match_count), 3);
      do_reset();
      load_example();
      send_id(5, 0, 1);
      send_id(1, 1, 1);
      finish_run("latency");
      do_reset();
      send_range(7, 7);
      send_range(9, 2);
      send_id(7, 0, 1);
      send_id(2, 0, 1);
      send_id(9, 0, 1);
      send_id(all1, 0, 1);
      send_range(0, all1);
      send_id(8, 1, 1);
      finish_run("bounds");
      do_reset();
      send_id(4, 0, 1);
      send_id(4, 1, 1);
      finish_run("empty");
      do_reset();
      for (int i = 0; i < MAXR; i++) send_range(64'(i * 10), 64'(i * 10 + 3));
      send_range(0, all1);
      send_id(2552, 0, 1);
      send_id(2555, 0, 1);
      send_id(3, 0, 1);
      send_id(5000, 1, 1);
      finish_run("range_ovf");
      do_reset();
      send_range(0, 9);
      for (int i = 0; i <= DEPTH; i++) send_id(64'($urandom_range(0, 19)), i == DEPTH, 1);
      finish_run("depth_ovf");
      do_reset();
      load_example();
      send_id(17, 0, 0);
      do_reset();
      send_id(4, 1, 1);
      finish_run("post_reset_nr0");
      do_reset();
      load_example();
      example_ids();
      finish_run("reload");
      for (int r = 0; r < 6; r++) begin
         int nr, nid;
         do_reset();
         nr = $urandom_range(0, 8);
         nid = $urandom_range(1, 15);
         for (int i = 0; i < nr; i++) begin
            lo = 64'($urandom_range(10, 60));
            hi = ($urandom_range(0, 5) == 0) ? lo - 64'($urandom_range(1, 9)) : lo + 64'($urandom_range(0, 20));
            send_range(lo, hi);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
         end
         for (int i = 0; i < nid; i++) begin
            send_id(64'($urandom_range(0, 90)), i == nid - 1, 1);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 4));
         end
         finish_run("random");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
